// File: rtl/t03_wishbone_subordinate.sv
// rtl/t03_wishbone_subordinate.sv - Wishbone classic-cycle subordinate: page decode,
// byte-lane register-file SRAM and a programmable wait-state count before ACK.
module t03_wishbone_subordinate #(
  parameter logic [7:0] BASE_PAGE   = 8'h33,
  parameter int         DEPTH_WORDS = 256,
  parameter int         WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        BUSY_O
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] req_idx;
  logic          req_oor;
  logic          req_we;
  logic [31:0]   req_dat;
  logic [3:0]    req_sel;
  logic [31:0]   mem [DEPTH_WORDS];

  logic hit;
  logic bus_held;
  logic in_range;
  logic unused_adr;

  assign bus_held   = CYC_I & STB_I;
  assign hit        = bus_held & (ADR_I[31:24] == BASE_PAGE);
  assign in_range   = (ADR_I[23:AW+2] == '0);
  assign unused_adr = ^ADR_I[1:0];

  // State register plus the request latch; later bus changes cannot disturb a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      req_idx  <= '0;
      req_oor  <= 1'b0;
      req_we   <= 1'b0;
      req_dat  <= '0;
      req_sel  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && hit) begin
        req_idx  <= ADR_I[AW+1:2];
        req_oor  <= ~in_range;
        req_we   <= WE_I;
        req_dat  <= DAT_I;
        req_sel  <= SEL_I;
        wait_cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      end else if (state == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (hit) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      end
      S_WAIT: begin
        if (!bus_held)            state_next = S_IDLE;
        else if (wait_cnt == 4'd0) state_next = S_ACK;
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decode from state only, so an async reset clears them without a clock edge.
  always_comb begin
    ACK_O  = 1'b0;
    BUSY_O = 1'b0;
    DAT_O  = '0;
    case (state)
      S_WAIT: BUSY_O = 1'b1;
      S_ACK: begin
        ACK_O  = 1'b1;
        BUSY_O = 1'b1;
        if (!req_we && !req_oor) DAT_O = mem[req_idx];
      end
      default: ;
    endcase
  end

  // Writes commit at the end of the ACK cycle; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (state == S_ACK && req_we && !req_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_t03_wishbone_subordinate.sv
// tb/tb_t03_wishbone_subordinate.sv - randomized self-checking bench for t03_wishbone_subordinate
// against a cycle-timeline memory model.
module tb_t03_wishbone_subordinate;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ADR_I = '0;
  logic [31:0] DAT_I = '0;
  logic [3:0]  SEL_I = '0;
  logic        WE_I  = 1'b0;
  logic        STB_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        BUSY_O;

  t03_wishbone_subordinate #(
    .BASE_PAGE  (8'h33),
    .DEPTH_WORDS(256),
    .WAIT_STATES(WS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ADR_I (ADR_I),
    .DAT_I (DAT_I),
    .SEL_I (SEL_I),
    .WE_I  (WE_I),
    .STB_I (STB_I),
    .CYC_I (CYC_I),
    .DAT_O (DAT_O),
    .ACK_O (ACK_O),
    .BUSY_O(BUSY_O)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory contents plus per-cycle expected outputs.
  logic [31:0] model_mem [256];
  bit          exp_ack  [int];
  bit          exp_busy [int];
  logic [31:0] exp_dat  [int];

  int          n_chk = 0;
  int          n_pass = 0;
  int          acks_seen = 0;
  int          last_lat;
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    bit ea;
    bit eb;
    ea = exp_ack.exists(cyc)  ? exp_ack[cyc]  : 1'b0;
    eb = exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0;
    check("ack",  {31'd0, ACK_O},  {31'd0, ea});
    check("busy", {31'd0, BUSY_O}, {31'd0, eb});
    if (exp_dat.exists(cyc)) check("dat", DAT_O, exp_dat[cyc]);
    if (ACK_O) acks_seen++;
  end

  task automatic garble();
    ADR_I = $urandom;
    DAT_I = $urandom;
    SEL_I = 4'($urandom);
    WE_I  = 1'($urandom);
  endtask

  // mode 0: normal transfer; 1: abort after cut cycles; 2: reset after cut cycles.
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int mode, input int cut);
    int c0;
    bit inr;
    int idx;
    c0  = cyc;
    inr = (adr[23:10] == 14'd0);
    idx = int'(adr[9:2]);
    CYC_I = 1'b1; STB_I = 1'b1;
    ADR_I = adr; DAT_I = dat; SEL_I = sel; WE_I = we;
    if (mode == 0) begin
      for (int k = 1; k <= WS + 1; k++) exp_busy[c0 + k] = 1'b1;
      exp_ack[c0 + WS + 1] = 1'b1;
      exp_dat[c0 + WS + 1] = (!we && inr) ? model_mem[idx] : 32'h0;
      exp_dat[c0 + WS + 2] = 32'h0;
      if (we && inr) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
      end
      last_lat = -1;
      last_rd  = 32'hx;
      for (int k = 1; k <= WS + 1; k++) begin
        @(posedge clk); #1;
        if (ACK_O && last_lat < 0) begin
          last_lat = cyc - c0;
          last_rd  = DAT_O;
        end
        garble();
      end
      @(posedge clk); #1;
      CYC_I = 1'b0; STB_I = 1'b0;
    end else if (mode == 1) begin
      for (int k = 1; k <= cut; k++) exp_busy[c0 + k] = 1'b1;
      repeat (cut) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 0) CYC_I = 1'b0;
      else                           STB_I = 1'b0;
      @(posedge clk); #1;
      CYC_I = 1'b0; STB_I = 1'b0;
    end else begin
      for (int k = 1; k < cut; k++) exp_busy[c0 + k] = 1'b1;
      repeat (cut) @(posedge clk);
      #1;
      check("busy_before_rst", {31'd0, BUSY_O}, 32'd1);
      rst = 1'b1;
      CYC_I = 1'b0; STB_I = 1'b0;
      #1;
      check("rst_ack",  {31'd0, ACK_O},  32'd0);
      check("rst_busy", {31'd0, BUSY_O}, 32'd0);
      check("rst_dat",  DAT_O, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  // Bus noise that must never be taken as a hit.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ADR_I = $urandom; DAT_I = $urandom; SEL_I = 4'($urandom); WE_I = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin CYC_I = 1'b0; STB_I = 1'b0; end
        1: begin CYC_I = 1'b0; STB_I = 1'b1; ADR_I[31:24] = 8'h33; end
        2: begin CYC_I = 1'b1; STB_I = 1'b0; ADR_I[31:24] = 8'h33; end
        default: begin
          CYC_I = 1'b1; STB_I = 1'b1;
          ADR_I[31:24] = 8'h33 ^ 8'($urandom_range(1, 255));
        end
      endcase
      @(posedge clk); #1;
    end
    CYC_I = 1'b0; STB_I = 1'b0;
  endtask

  function automatic logic [31:0] rand_adr();
    logic [31:0] a;
    a = $urandom;
    a[31:24] = 8'h33;
    if ($urandom_range(0, 9) != 0) a[23:10] = '0;
    a[9:2] = 8'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int a0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack",  {31'd0, ACK_O},  32'd0);
    check("reset_busy", {31'd0, BUSY_O}, 32'd0);
    check("reset_dat",  DAT_O, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    a0 = acks_seen;
    CYC_I = 1'b1; STB_I = 1'b1; ADR_I = 32'h4400_0000; WE_I = 1'b0; SEL_I = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    CYC_I = 1'b0; STB_I = 1'b0;
    check("wrong_page_no_ack", acks_seen - a0, 32'd0);

    for (int i = 0; i < 256; i++)
      xfer(1'b1, 32'h3300_0000 | (i << 2), $urandom, 4'hF, 0, 0);

    xfer(1'b1, 32'h3300_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
    check("wr_latency", last_lat, 32'd4);
    xfer(1'b0, 32'h3300_0010, 32'h0, 4'hF, 0, 0);
    check("rd_latency", last_lat, 32'd4);
    check("rd_deadbeef", last_rd, 32'hDEAD_BEEF);

    xfer(1'b1, 32'h3300_0020, 32'h1122_3344, 4'hF, 0, 0);
    xfer(1'b1, 32'h3300_0020, 32'hAABB_CCDD, 4'b0101, 0, 0);
    xfer(1'b0, 32'h3300_0020, 32'h0, 4'hF, 0, 0);
    check("byte_lanes", last_rd, 32'h11BB_33DD);

    xfer(1'b1, 32'h3300_0000, 32'h0BAD_F00D, 4'hF, 0, 0);
    xfer(1'b1, 32'h3300_0400, 32'hFFFF_FFFF, 4'hF, 0, 0);
    check("oor_wr_acks", last_lat, 32'd4);
    xfer(1'b0, 32'h3300_0400, 32'h0, 4'hF, 0, 0);
    check("oor_rd_zero", last_rd, 32'h0);
    xfer(1'b0, 32'h3300_0000, 32'h0, 4'hF, 0, 0);
    check("oor_word0_kept", last_rd, 32'h0BAD_F00D);

    xfer(1'b1, 32'h3300_0020, 32'h0000_0000, 4'h0, 0, 0);
    xfer(1'b0, 32'h3300_0020, 32'h0, 4'hF, 0, 0);
    check("sel0_no_change", last_rd, 32'h11BB_33DD);

    xfer(1'b1, 32'h3300_0030, 32'h5555_AAAA, 4'hF, 0, 0);
    idle(2);
    a0 = acks_seen;
    xfer(1'b1, 32'h3300_0030, 32'h1234_5678, 4'hF, 1, 1);
    idle(3);
    check("abort_no_ack", acks_seen - a0, 32'd0);
    xfer(1'b0, 32'h3300_0030, 32'h0, 4'hF, 0, 0);
    check("abort_old_value", last_rd, 32'h5555_AAAA);

    xfer(1'b1, 32'h3300_0040, 32'hC0FF_EE00, 4'hF, 0, 0);
    xfer(1'b1, 32'h3300_0040, 32'hFFFF_FFFF, 4'hF, 2, 2);
    xfer(1'b0, 32'h3300_0040, 32'h0, 4'hF, 0, 0);
    check("rst_latency", last_lat, 32'd4);
    check("rst_no_commit", last_rd, 32'hC0FF_EE00);

    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op == 0)
        xfer(1'($urandom), rand_adr(), $urandom, 4'($urandom), 1, $urandom_range(1, WS));
      else if (op == 1)
        xfer(1'($urandom), rand_adr(), $urandom, 4'($urandom), 2, $urandom_range(1, WS + 1));
      else
        xfer(1'($urandom), rand_adr(), $urandom, 4'($urandom), 0, 0);
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/t03_wishbone_subordinate.md
Name: t03_wishbone_subordinate

Overview:
- Wishbone classic-cycle responder: the subordinate end of the bus driven by the team's Wishbone manager (the one fed by the MMIO block).
- Decodes the 8-bit page prefix, serves word-addressed reads/writes from an internal register-file SRAM with byte-lane enables, and inserts a programmable number of wait states before ACK.
- Serves as the on-chip scratch memory and as a protocol-correct bench target for the manager path.

Parameters:
- BASE_PAGE, 8'h33: required value of ADR_I[31:24] for the block to respond.
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, 4..1024.
- WAIT_STATES, 1: idle cycles between request accept and ACK; 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ADR_I  input  32  byte address from the manager; bits [1:0] ignored.
- DAT_I  input  32  write data from the manager.
- SEL_I  input  4  byte-lane enables; bit i covers DAT[8i+7:8i].
- WE_I  input  1  1 = write, 0 = read.
- STB_I  input  1  strobe.
- CYC_I  input  1  bus cycle active.
- DAT_O  output  32  read data; valid only while ACK_O=1.
- ACK_O  output  1  single-cycle transfer acknowledge.
- BUSY_O  output  1  high from accept until the ACK cycle, inclusive.

Behaviour:
- Reset (async, rst=1): state=IDLE, ACK_O=0, DAT_O=0, BUSY_O=0, wait counter=0, latched request cleared.
  - Memory contents are not reset; they are undefined until written.
- Hit condition: CYC_I & STB_I & (ADR_I[31:24]==BASE_PAGE). Any non-hit is ignored: no ACK, no state change.
- Word index: ADR_I[log2(DEPTH_WORDS)+1:2]. ADR_I[23:log2(DEPTH_WORDS)+2] nonzero means out of range.
- States:
  - IDLE: on a hit, latch ADR/DAT/SEL/WE and set BUSY_O=1. Go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1), otherwise go to ACK.
  - WAIT: decrement the counter each cycle; when the counter==0, go to ACK. If CYC_I or STB_I drops, abort to IDLE with no memory update and no ACK.
  - ACK: ACK_O=1 for exactly one cycle, then go to IDLE.
    - Reads: DAT_O = mem[index] during this cycle; DAT_O returns to 0 the next cycle.
    - Writes: lanes with SEL=1 commit at the end of the ACK cycle; lanes with SEL=0 are untouched. DAT_O=0 during write ACKs.
- Latency from the accept edge to ACK_O high is WAIT_STATES+1 cycles.
  - Minimum back-to-back spacing is WAIT_STATES+2 cycles, because IDLE must be re-entered before the next accept.
- A hit sampled in the ACK cycle is not accepted. It is accepted in the following IDLE cycle if STB_I is still high.
  - The manager drops STB_I after seeing ACK, so no duplicate transfer occurs.
- Out of range: the transfer still ACKs on normal timing. Reads return 32'h0; writes are dropped.
- SEL_I=4'b0000 write: ACKs normally and changes no memory.
- Input changes after accept (ADR/DAT/SEL/WE) are ignored; the latched copy is used.
- Reset asserted mid-transfer: immediate return to IDLE with ACK_O=0. A pending write is discarded.
- Read-after-write to the same word in back-to-back transfers returns the new data; the commit precedes the next accept.

Test Plan:
- Reset then idle bus: ACK_O=0, DAT_O=0, BUSY_O=0; STB_I=1 with ADR_I=32'h4400_0000 → never ACKs.
- WAIT_STATES=1: write ADR=32'h3300_0010, DAT=32'hDEAD_BEEF, SEL=4'hF; then read the same address → ACK 2 cycles after each accept; read DAT_O=32'hDEAD_BEEF.
- Byte lanes: word 32'h1122_3344 at 0x3300_0020, then write DAT=32'hAABB_CCDD with SEL=4'b0101 → read returns 32'h11BB_33DD.
- Out of range, DEPTH_WORDS=256: write then read ADR=32'h3300_0400 → both ACK; read returns 0; word 0 unchanged.
- Abort: WAIT_STATES=3, start a write, drop CYC_I after 1 cycle → no ACK; later read of that word shows the old value.
- Async reset: assert rst during WAIT of a write → ACK_O, BUSY_O fall without a clock edge; no memory update; the next transfer completes with normal latency.
